// File: rtl/alu_pkg.sv
// Shared types, framing constants and CRC helpers for the mtm_Alu request arbiter.
package alu_pkg;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b100,
    SUB = 3'b101
  } operation_t;

  typedef enum logic [2:0] {IDLE, ARB, TX, RX_WAIT, RX_FRAME, DONE} arb_state_t;

  localparam int FRAME_BITS     = 11;
  localparam int TX_DATA_FRAMES = 8;
  localparam int RX_DATA_FRAMES = 4;
  localparam int TX_BITS        = FRAME_BITS * (TX_DATA_FRAMES + 1);

  // x^4+x+1, init 0, MSB first over {B, A, 1'b1, op}
  function automatic logic [3:0] crc4_68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = d[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // x^3+x+1, init 0, MSB first over {C, 1'b0, flags}
  function automatic logic [2:0] crc3_37(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = d[i] ^ c[2];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Two-flop synchronizer on sout plus 11-bit frame deserializer.
// Emits a one-cycle frame_valid with type/data once the stop bit is sampled.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sout,
  output logic       busy,
  output logic       frame_valid,
  output logic       frame_type,
  output logic [7:0] frame_data,
  output logic       framing_err
);

  logic       s1_q, s2_q;
  logic       active_q, active_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] sr_q, sr_d;
  logic       vld_q, vld_d, typ_q, typ_d, ferr_q, ferr_d;
  logic [7:0] dat_q, dat_d;

  // start bit detect, then shift type+data, check stop on the tenth bit
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    vld_d    = 1'b0;
    typ_d    = typ_q;
    dat_d    = dat_q;
    ferr_d   = ferr_q;
    if (!en) begin
      active_d = 1'b0;
    end else if (!active_q) begin
      if (!s2_q) begin
        active_d = 1'b1;
        cnt_d    = '0;
      end
    end else if (cnt_q == 4'(FRAME_BITS - 2)) begin
      active_d = 1'b0;
      vld_d    = 1'b1;
      typ_d    = sr_q[8];
      dat_d    = sr_q[7:0];
      ferr_d   = ~s2_q;
    end else begin
      sr_d  = {sr_q[7:0], s2_q};
      cnt_d = cnt_q + 4'd1;
    end
  end

  // sync chain and deserializer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      active_q <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      vld_q    <= 1'b0;
      typ_q    <= 1'b0;
      dat_q    <= '0;
      ferr_q   <= 1'b0;
    end else begin
      s1_q     <= sout;
      s2_q     <= s1_q;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      vld_q    <= vld_d;
      typ_q    <= typ_d;
      dat_q    <= dat_d;
      ferr_q   <= ferr_d;
    end
  end

  assign busy        = active_q;
  assign frame_valid = vld_q;
  assign frame_type  = typ_q;
  assign frame_data  = dat_q;
  assign framing_err = ferr_q;

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one serial mtm_Alu between N_REQ requesters.
// Builds and shifts the 99-bit command packet onto sin, collects the response
// frames from sout and returns result/flags/status to the winner.
// Optional: define ALU_ARB_TIMEOUT_EN to bound the wait for each response frame.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0][31:0] req_a,
  input  logic [N_REQ-1:0][31:0] req_b,
  input  logic [N_REQ-1:0][2:0] req_op,
  output logic [N_REQ-1:0]      ack,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_c,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [7:0]            rsp_status,
  output logic                  busy,
  output logic                  sin,
  input  logic                  sout
);

  localparam int PW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("alu_req_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  arb_state_t          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, win_q, win_d, grant_idx;
  logic                grant_vld;
  logic [TX_BITS-1:0]  pkt, tx_sr_q, tx_sr_d;
  logic [6:0]          tx_cnt_q, tx_cnt_d;
  logic                sin_q, sin_d;
  logic [2:0]          rx_idx_q, rx_idx_d;
  logic [31:0]         c_q, c_d, rsp_c_q, rsp_c_d;
  logic [3:0]          flags_q, flags_d, rsp_flags_q, rsp_flags_d;
  logic [7:0]          status_q, status_d, rsp_status_q, rsp_status_d;
  logic                err_q, err_d, rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic [63:0]         ba;
  logic                rx_en, rx_busy, rx_valid, rx_type, rx_ferr;
  logic [7:0]          rx_data;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
`endif

  assign rx_en = (state_q == RX_WAIT) || (state_q == RX_FRAME);

  alu_frame_rx u_rx (
    .clk(clk), .rst_n(rst_n), .en(rx_en), .sout(sout), .busy(rx_busy),
    .frame_valid(rx_valid), .frame_type(rx_type), .frame_data(rx_data),
    .framing_err(rx_ferr)
  );

  // round-robin pick starting at ptr_q; lowest offset wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // command packet for the current pick: 8 data frames then the op/crc4 frame
  always_comb begin
    ba  = {req_b[grant_idx], req_a[grant_idx]};
    pkt = '0;
    for (int i = 0; i < TX_DATA_FRAMES; i++)
      pkt[TX_BITS-1-FRAME_BITS*i -: FRAME_BITS] = {2'b00, ba[63-8*i -: 8], 1'b1};
    pkt[FRAME_BITS-1:0] = {2'b01, 1'b0, req_op[grant_idx],
                           crc4_68({ba, 1'b1, req_op[grant_idx]}), 1'b1};
  end

  // arbiter / serializer / response collector FSM next state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    tx_sr_d      = tx_sr_q;
    tx_cnt_d     = tx_cnt_q;
    sin_d        = sin_q;
    rx_idx_d     = rx_idx_q;
    c_d          = c_q;
    flags_d      = flags_q;
    status_d     = status_q;
    err_d        = err_q;
    rsp_c_d      = rsp_c_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_status_d = rsp_status_q;
    rsp_err_d    = rsp_err_q;
    ack_d        = '0;
    rsp_valid_d  = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
    tmo_d        = '0;
`endif
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (grant_vld) begin
          // start bit goes out on the same edge the operands are captured
          win_d    = grant_idx;
          sin_d    = pkt[TX_BITS-1];
          tx_sr_d  = {pkt[TX_BITS-2:0], 1'b1};
          tx_cnt_d = '0;
          rx_idx_d = '0;
          c_d      = '0;
          flags_d  = '0;
          status_d = '0;
          err_d    = 1'b0;
          state_d  = TX;
        end else begin
          state_d = IDLE;
        end
      end
      TX: begin
        if (tx_cnt_q == 7'(TX_BITS - 1)) begin
          sin_d   = 1'b1;
          state_d = RX_WAIT;
        end else begin
          sin_d    = tx_sr_q[TX_BITS-1];
          tx_sr_d  = {tx_sr_q[TX_BITS-2:0], 1'b1};
          tx_cnt_d = tx_cnt_q + 7'd1;
        end
      end
      RX_WAIT: begin
        if (rx_busy) begin
          state_d = RX_FRAME;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d    = 1'b1;
          status_d = 8'hFF;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RX_FRAME: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (!rx_type) begin
            if (rx_idx_q < 3'(RX_DATA_FRAMES)) begin
              c_d      = {c_q[23:0], rx_data};
              rx_idx_d = rx_idx_q + 3'd1;
              state_d  = RX_WAIT;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            // CTL frame ends the response; first-frame CTL is an ALU error
            status_d = rx_data;
            state_d  = DONE;
            if (rx_idx_q == 3'(RX_DATA_FRAMES)) begin
              flags_d = rx_data[6:3];
              err_d   = crc3_37({c_q, 1'b0, rx_data[6:3]}) != rx_data[2:0];
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) begin
      rsp_valid_d  = 1'b1;
      ack_d        = N_REQ'(1) << win_q;
      rsp_c_d      = c_d;
      rsp_flags_d  = flags_d;
      rsp_status_d = status_d;
      rsp_err_d    = err_d;
    end
    busy_d = (state_d != IDLE);
  end

  // all FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      tx_sr_q      <= '1;
      tx_cnt_q     <= '0;
      sin_q        <= 1'b1;
      rx_idx_q     <= '0;
      c_q          <= '0;
      flags_q      <= '0;
      status_q     <= '0;
      err_q        <= 1'b0;
      rsp_c_q      <= '0;
      rsp_flags_q  <= '0;
      rsp_status_q <= '0;
      rsp_err_q    <= 1'b0;
      ack_q        <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      tx_sr_q      <= tx_sr_d;
      tx_cnt_q     <= tx_cnt_d;
      sin_q        <= sin_d;
      rx_idx_q     <= rx_idx_d;
      c_q          <= c_d;
      flags_q      <= flags_d;
      status_q     <= status_d;
      err_q        <= err_d;
      rsp_c_q      <= rsp_c_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_status_q <= rsp_status_d;
      rsp_err_q    <= rsp_err_d;
      ack_q        <= ack_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign sin        = sin_q;
  assign ack        = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_status = rsp_status_q;
  assign busy       = busy_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one serial mtm_Alu instance between N_REQ parallel requesters.
- For each granted request it builds and serializes the command packet onto sin, then deserializes the response from sout.
- Returns result, flags and error status to the winner. Sits between the block's clients and the ALU's clk/rst_n/sin/sout pins.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 2000, cycles allowed from last TX bit to first response start bit (used only with ALU_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  posedge clock shared with mtm_Alu
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request, held until ack
- req_a  in  N_REQ*32  operand A per requester
- req_b  in  N_REQ*32  operand B per requester
- req_op  in  N_REQ*3  opcode per requester
- ack  out  N_REQ  one-cycle pulse to the served requester, coincident with rsp_valid
- rsp_valid  out  1  one-cycle response strobe
- rsp_c  out  32  result C
- rsp_flags  out  4  {carry, overflow, zero, negative}
- rsp_err  out  1  ALU returned an error frame, CRC mismatch, or timeout
- rsp_status  out  8  raw data byte of the final response CTL frame
- busy  out  1  high from grant to rsp_valid inclusive
- sin  out  1  serial data to ALU (idle 1)
- sout  in  1  serial data from ALU

Behaviour:
- Reset: sin=1; ack=0, rsp_valid=0, busy=0; rsp_c/flags/status=0, rsp_err=0; round-robin pointer=0; FSM to IDLE. Reset mid-packet aborts immediately; no partial response is issued.
- Frame: 11 bits, one bit per clk: start 0, type (0=data, 1=ctl), 8 data bits MSB first, stop 1.
- TX packet: 8 data frames B[31:24]..B[7:0], A[31:24]..A[7:0], then a CTL frame {0, op[2:0], crc4}.
  - crc4 = CRC x^4+x+1, init 0, over the 68 bits {B, A, 1'b1, op}.
  - Frames are back-to-back with no idle gap.
- RX, normal response: 4 data frames C MSB byte first, then CTL {0, flags[3:0], crc3}.
  - crc3 = CRC x^3+x+1, init 0, over {C, 1'b0, flags}.
- RX, error response: a single CTL frame as the first frame, with data[7]=1. Latch rsp_status and set rsp_err=1; rsp_c and rsp_flags are held at 0.
- FSM:
  - IDLE: when any req is set, go to ARB.
  - ARB (1 cycle): round-robin grant starting at pointer; latch the winner's operands; busy=1.
  - TX: 99 bit-cycles.
  - RX_WAIT: wait for sout=0.
  - RX_FRAME: shift 10 more bits. A frame is complete on the stop bit; go to RX_WAIT for the next frame or to DONE.
  - DONE (1 cycle): rsp_valid=1, ack[winner]=1; pointer = winner+1 mod N_REQ; return to IDLE.
- Latency: request to first sin bit = 2 cycles. Request to rsp_valid ≈ 101 + ALU turnaround + 55 cycles.
- Operands are latched at grant; later changes to req_* are ignored.
- A requester that deasserts req before grant is simply skipped.
- A frame with stop bit 0 is a framing error: rsp_err=1, go to DONE.
- A CRC3 mismatch sets rsp_err=1 but still delivers rsp_c and rsp_flags.
- Simultaneous requests: only one is served per packet; the others wait, with no starvation, by round-robin.
- sout is double-registered before use.

Optional Feature:
- ALU_ARB_TIMEOUT_EN defined:
  - A counter runs in RX_WAIT. Reaching TIMEOUT_CYC forces DONE with rsp_err=1 and rsp_status=8'hFF.
  - The counter restarts on each new RX_WAIT entry.
- ALU_ARB_TIMEOUT_EN undefined: RX_WAIT waits indefinitely; the counter logic is absent.

Decomposition:
- alu_pkg holds:
  - operation_t enum: AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101.
  - arb_state_t enum.
  - Constants FRAME_BITS=11, TX_DATA_FRAMES=8, RX_DATA_FRAMES=4.
  - Functions crc4_68 and crc3_37, shared with the testbench scoreboard.
- One sub-module, alu_frame_rx: synchronizer plus 11-bit deserializer, outputs {frame_valid, type, data[7:0], framing_err}.

Test Plan:
- req[0], A=1, B=2, ADD -> sin carries 99 bits with the correct crc4; rsp_c=3, flags=4'b0000, rsp_err=0, ack[0] pulses.
- req[1], A=32'h8000_0000, B=32'h8000_0000, ADD -> rsp_c=0, flags=carry|overflow|zero (4'b1110), ack[1].
- req[0] and req[1] raised together, three rounds -> grant order 0,1,0; each ack exactly once per packet.
- Opcode 3'b111 -> ALU error frame; rsp_err=1, rsp_status[7]=1, rsp_c=0.
- rst_n pulsed low at TX bit 40 -> sin=1 within 0 cycles, no rsp_valid; the next request completes normally.
- With ALU_ARB_TIMEOUT_EN and sout forced to 1 -> rsp_valid exactly TIMEOUT_CYC cycles after TX end, rsp_err=1, rsp_status=8'hFF.
